// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through a 4-phase valid/ack handshake.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag and its clear input.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_en_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_data_valid_o,
    input  logic                  tx_ack_i
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                  overflow_o,
    input  logic                  ovf_clr_i
`endif
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StPresent, StRelease} state_e;

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    state_e                state_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  wr_accept;
    logic                  pop;

    assign full_o          = (level_q == LvlW'(Depth));
    assign empty_o         = (level_q == '0);
    assign level_o         = level_q;
    assign tx_data_o       = tx_data_q;
    assign tx_data_valid_o = tx_valid_q;

    // Fullness is judged on the registered level, before any same-cycle pop.
    assign wr_accept = wr_en_i && !full_o;
    assign pop       = (state_q == StIdle) && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (wr_accept && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!wr_accept && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // RELEASE waits for ack to fall so valid stays low at least one cycle between bytes.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_valid_q <= 1'b1;
                        state_q    <= StPresent;
                    end
                end
                StPresent: begin
                    if (tx_ack_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StRelease;
                    end
                end
                StRelease: begin
                    if (!tx_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q;

    // A rejected write wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            overflow_q <= 1'b0;
        end else if (wr_en_i && full_o) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue-based reference model, per-cycle compare,
// in-order delivery scoreboard and a few literal checks.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int          Depth      = 16;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                wr_en = 1'b0;
    logic                full, empty;
    logic [DEPTH_LOG2:0] level;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ack = 1'b0;
    logic                overflow;
    logic                ovf_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_i           (clk),
        .nrst_i          (nrst),
        .wr_data_i       (wr_data),
        .wr_en_i         (wr_en),
        .full_o          (full),
        .empty_o         (empty),
        .level_o         (level),
        .tx_data_o       (tx_data),
        .tx_data_valid_o (tx_valid),
        .tx_ack_i        (tx_ack)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .overflow_o      (overflow),
        .ovf_clr_i       (ovf_clr)
`endif
    );

`ifndef UART_TX_FIFO_OVF_EN
    assign overflow = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: bytes held in the FIFO, the byte on the output and handshake phase.
    logic [7:0] mq[$];
    logic [7:0] exp_s[$];
    int         m_phase = 0;  // 0 waiting for data, 1 presenting, 2 waiting for ack low
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf   = 1'b0;

    // Transmitter model state.
    bit ack_en   = 1'b0;
    int ack_dly  = 0;
    int ack_hold = 0;
    bit prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit was_full;
        was_full = (mq.size() == Depth);
        if (!nrst) begin
            mq.delete();
            exp_s.delete();
            m_phase = 0;
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (m_phase == 0 && mq.size() > 0) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
                m_phase = 1;
            end else if (m_phase == 1 && tx_ack) begin
                m_valid = 1'b0;
                m_phase = 2;
            end else if (m_phase == 2 && !tx_ack) begin
                m_phase = 0;
            end
            if (wr_en && !was_full) begin
                mq.push_back(wr_data);
                exp_s.push_back(wr_data);
            end
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("level", 32'(level), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == Depth));
        check("tx_data_valid", 32'(tx_valid), 32'(m_valid));
        if (m_valid) check("tx_data", 32'(tx_data), 32'(m_data));
`ifdef UART_TX_FIFO_OVF_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
`endif
        // In-order delivery: each new request must carry the oldest undelivered byte.
        if (tx_valid && !prev_valid) begin
            if (exp_s.size() == 0) begin
                check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                check("stream_order", 32'(tx_data), 32'(exp_s.pop_front()));
            end
            ack_dly = $urandom_range(0, 4);
        end
        prev_valid = tx_valid;
        if (!nrst) begin
            tx_ack = 1'b0;
        end else if (ack_en) begin
            if (!tx_valid) begin
                if (tx_ack) begin
                    if (ack_hold == 0) tx_ack = 1'b0;
                    else ack_hold--;
                end
            end else if (!tx_ack) begin
                if (ack_dly == 0) begin
                    tx_ack   = 1'b1;
                    ack_hold = $urandom_range(0, 2);
                end else begin
                    ack_dly--;
                end
            end
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int i;
        ack_en = 1'b1;
        for (i = 0; i < 600; i++) begin
            if (mq.size() == 0 && m_phase == 0 && !tx_valid && !tx_ack) break;
            step();
        end
        check("drain_timeout", 32'(i < 600), 32'd1);
        check("all_delivered", 32'(exp_s.size()), 32'd0);
    endtask

    initial begin
        int writes;
        int i;

        // Reset
        nrst = 1'b0;
        step();
        step();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        nrst = 1'b1;
        step();

        // Single byte with a slow ack
        ack_en = 1'b0;
        write(8'hA5);
        check("single_lvl1", 32'(level), 32'd1);
        check("single_nv1", 32'(tx_valid), 32'd0);
        step();
        check("single_valid", 32'(tx_valid), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        for (int k = 0; k < 10; k++) step();
        check("single_hold", 32'(tx_valid), 32'd1);
        tx_ack = 1'b1;
        step();
        check("single_drop", 32'(tx_valid), 32'd0);
        tx_ack = 1'b0;
        step();
        step();
        check("single_empty", 32'(empty), 32'd1);
        check("single_idle", 32'(tx_valid), 32'd0);

        // Burst of 16: one byte moves to the output register, so one more fills the FIFO
        for (int k = 1; k <= 16; k++) write(8'(k));
        check("burst_lvl15", 32'(level), 32'd15);
        check("burst_nfull", 32'(full), 32'd0);
        write(8'h11);
        check("burst_lvl16", 32'(level), 32'd16);
        check("burst_full", 32'(full), 32'd1);

        // Overflow: EE must be dropped
        write(8'hEE);
        check("ovf_lvl", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
`endif
        drain();

        // Hold level 8 with simultaneous write+pop, wrapping the pointers
        ack_en = 1'b0;
        for (int k = 0; k < 9; k++) write(8'($urandom));
        check("wrap_lvl8", 32'(level), 32'd8);
        ack_en = 1'b1;
        writes = 0;
        for (i = 0; i < 1000 && writes < 40; i++) begin
            wr_en   = (m_phase == 0 && mq.size() > 0);
            wr_data = 8'($urandom);
            if (wr_en) writes++;
            step();
        end
        wr_en = 1'b0;
        check("wrap_count", 32'(writes), 32'd40);
        check("wrap_lvl_end", 32'(level), 32'd8);
        drain();

        // Reset while presenting
        ack_en = 1'b0;
        write(8'h3C);
        write(8'h4D);
        write(8'h5E);
        for (i = 0; i < 20 && !tx_valid; i++) step();
        check("midrst_present", 32'(tx_valid), 32'd1);
        nrst = 1'b0;
        step();
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        nrst = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("midrst_nostale", 32'(tx_valid), 32'd0);

        // Random traffic with occasional clears and resets
        ack_en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            wr_en   = ($urandom_range(0, 99) < ((k / 250) % 2 ? 70 : 25));
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 19) == 0);
            nrst    = ($urandom_range(0, 399) != 0);
            step();
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        nrst    = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
